// File: rtl/d8_loader.sv
// d8_loader: UART program loader for the dumb8 core.
//
// Receives framed bytes on a UART line (8N1) and writes the payload into the
// instruction memory write port. The core is held in reset while a frame is
// being loaded and released only after a frame with a valid checksum.
//
// Frame: 0xA5, LEN, ADDR, LEN data bytes, SUM
//        valid iff (LEN + ADDR + data... + SUM) mod 256 == 0
//
// Parameters:
//   CLK_PER_BIT     sys_clk cycles per UART bit (minimum 4)
//   TIMEOUT_CYCLES  inter-byte gap limit inside a frame (timeout build only)
//
// Optional feature macro:
//   LOADER_TIMEOUT_EN  when defined, a frame that stalls for TIMEOUT_CYCLES
//                      between bytes is abandoned with err set.
//
// Ports:
//   sys_clk   in   system clock, rising edge
//   sys_rst   in   synchronous active-high reset
//   rx        in   UART receive line, idle high, asynchronous
//   mem_we    out  instruction memory write strobe, one cycle per data byte
//   mem_addr  out  instruction memory write address
//   mem_data  out  instruction memory write data
//   cpu_rst   out  core reset, active-high
//   done      out  one-cycle pulse when a frame is accepted
//   err       out  sticky flag: last frame failed (checksum/framing/timeout)

module d8_loader #(
    parameter int CLK_PER_BIT    = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       cpu_rst,
    output logic       done,
    output logic       err
);

    localparam logic [15:0] BIT_LAST  = 16'(CLK_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_PER_BIT / 2 - 1);
    localparam logic [7:0]  HDR_BYTE  = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        F_HDR,
        F_LEN,
        F_ADDR,
        F_DATA,
        F_SUM
    } frame_state_t;

    // UART receiver state
    logic        rx_meta, rx_s, rx_prev;
    rx_state_t   rx_state, rx_state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bitidx, bitidx_n;
    logic [7:0]  shift, shift_n;
    logic        byte_valid, byte_valid_n;
    logic        frame_err, frame_err_n;

    // Frame parser state
    frame_state_t fstate, fstate_n;
    logic [7:0]   len, len_n;
    logic [7:0]   sum, sum_n;
    logic [7:0]   sum_plus;
    logic [7:0]   addr_n, data_n;
    logic         we_n, done_n, cpu_rst_n, err_n;

    // Two-stage synchronizer for the asynchronous rx line; rx_prev gives the
    // previous synchronized value so a falling edge can be seen in idle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Receiver registers. byte_valid and frame_err are single-cycle pulses;
    // shift holds the received byte until the next byte starts shifting in.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bitidx     <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            cnt        <= cnt_n;
            bitidx     <= bitidx_n;
            shift      <= shift_n;
            byte_valid <= byte_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    // Receiver next state. The start bit is confirmed half a bit after the
    // falling edge; from then on every sample lands a full bit period later,
    // which is the middle of each data bit and of the stop bit.
    always_comb begin
        rx_state_n   = rx_state;
        cnt_n        = cnt;
        bitidx_n     = bitidx;
        shift_n      = shift;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    cnt_n      = '0;
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        bitidx_n   = '0;
                        rx_state_n = RX_DATA;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[7:1]};
                    if (bitidx == 3'd7) begin
                        rx_state_n = RX_STOP;
                    end else begin
                        bitidx_n = bitidx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n      = '0;
                    rx_state_n = RX_IDLE;
                    if (rx_s) begin
                        byte_valid_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

`ifdef LOADER_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tcnt, tcnt_n;
    logic        timeout_hit;

    // Gap counter: cleared in HDR and on every received byte, so it measures
    // the silence since the last byte of the frame in progress.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt_n;
        end
    end

    always_comb begin
        timeout_hit = 1'b0;
        if (fstate == F_HDR || byte_valid) begin
            tcnt_n = '0;
        end else if (tcnt == TO_LAST) begin
            tcnt_n      = '0;
            timeout_hit = 1'b1;
        end else begin
            tcnt_n = tcnt + 32'd1;
        end
    end
`else
    logic timeout_hit;
    assign timeout_hit = 1'b0;
`endif

    // Frame parser registers, including the registered memory write port
    // and the core reset / status outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fstate   <= F_HDR;
            len      <= '0;
            sum      <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            fstate   <= fstate_n;
            len      <= len_n;
            sum      <= sum_n;
            mem_we   <= we_n;
            mem_addr <= addr_n;
            mem_data <= data_n;
            cpu_rst  <= cpu_rst_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

    // Frame parser next state. A framing error outside HDR aborts the frame
    // but leaves cpu_rst alone; 0xA5 is only special in HDR, so frames never
    // resynchronise mid-stream. Writes are not rolled back on a bad frame.
    always_comb begin
        fstate_n  = fstate;
        len_n     = len;
        sum_n     = sum;
        we_n      = 1'b0;
        addr_n    = mem_addr;
        data_n    = mem_data;
        cpu_rst_n = cpu_rst;
        done_n    = 1'b0;
        err_n     = err;
        sum_plus  = sum + shift;

        // The address advances the cycle after each write strobe, ready for
        // the next data byte; it wraps naturally at 8 bits.
        if (mem_we) begin
            addr_n = mem_addr + 8'd1;
        end

        if (frame_err && fstate != F_HDR) begin
            err_n    = 1'b1;
            fstate_n = F_HDR;
        end else if (byte_valid) begin
            case (fstate)
                F_HDR: begin
                    if (shift == HDR_BYTE) begin
                        cpu_rst_n = 1'b1;
                        err_n     = 1'b0;
                        sum_n     = '0;
                        fstate_n  = F_LEN;
                    end
                end
                F_LEN: begin
                    len_n    = shift;
                    sum_n    = sum_plus;
                    fstate_n = F_ADDR;
                end
                F_ADDR: begin
                    addr_n   = shift;
                    sum_n    = sum_plus;
                    fstate_n = (len == 8'd0) ? F_SUM : F_DATA;
                end
                F_DATA: begin
                    we_n   = 1'b1;
                    data_n = shift;
                    sum_n  = sum_plus;
                    len_n  = len - 8'd1;
                    if (len == 8'd1) begin
                        fstate_n = F_SUM;
                    end
                end
                F_SUM: begin
                    if (sum_plus == 8'd0) begin
                        done_n    = 1'b1;
                        cpu_rst_n = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                    fstate_n = F_HDR;
                end
                default: fstate_n = F_HDR;
            endcase
        end else if (timeout_hit) begin
            err_n    = 1'b1;
            fstate_n = F_HDR;
        end
    end

endmodule

// File: tb/tb_d8_loader.sv
// tb_d8_loader: bench for d8_loader with CLK_PER_BIT=16.
// Bit-bangs UART frames on rx. Expected memory writes are queued when a frame
// is issued; a monitor thread pops and compares them whenever mem_we is seen.
// Status outputs (done count, cpu_rst, err) are compared after each frame.

module tb_d8_loader;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       rx;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       cpu_rst;
    logic       done;
    logic       err;

    int checks     = 0;
    int failures   = 0;
    int done_total = 0;
    int wr_ptr     = 0;
    int rd_ptr     = 0;
    int done_snap  = 0;
    logic [7:0] exp_addr [64];
    logic [7:0] exp_data [64];
    logic [7:0] frm [$];

    d8_loader #(
        .CLK_PER_BIT   (16),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .rx      (rx),
        .mem_we  (mem_we),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    always #5 sys_clk = ~sys_clk;

    // Record one comparison and report it if it does not match.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Queue an expected memory write.
    task automatic expectWrite(input logic [7:0] a, input logic [7:0] d);
        exp_addr[wr_ptr % 64] = a;
        exp_data[wr_ptr % 64] = d;
        wr_ptr++;
    endtask

    // Bit-bang one 8N1 byte; stop_ok=0 sends a low stop bit.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        repeat (16) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge sys_clk);
        end
        rx = stop_ok;
        repeat (16) @(negedge sys_clk);
        rx = 1'b1;
        repeat (6) @(negedge sys_clk);
    endtask

    // Send every byte in frm, then let the loader settle.
    task automatic sendFrame();
        done_snap = done_total;
        foreach (frm[i]) applyStimulus(frm[i], 1'b1);
        repeat (20) @(negedge sys_clk);
    endtask

    // Scoreboard monitor: pops an expected write on every mem_we, counts done.
    task automatic monitorLoop();
        forever begin
            @(negedge sys_clk);
            if (done) done_total++;
            if (mem_we) begin
                if (rd_ptr == wr_ptr) begin
                    checkOutput("unexpected write addr", {24'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("write addr", {24'd0, mem_addr}, {24'd0, exp_addr[rd_ptr % 64]});
                    checkOutput("write data", {24'd0, mem_data}, {24'd0, exp_data[rd_ptr % 64]});
                    rd_ptr++;
                end
            end
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        rx      = 1'b1;
        fork
            monitorLoop();
        join_none
        repeat (8) @(posedge sys_clk);
        @(negedge sys_clk);
        checkOutput("reset cpu_rst", {31'd0, cpu_rst}, 32'd1);
        checkOutput("reset mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset err", {31'd0, err}, 32'd0);
        checkOutput("reset mem_addr", {24'd0, mem_addr}, 32'd0);
        sys_rst = 1'b0;
        repeat (50) @(negedge sys_clk);
        checkOutput("idle cpu_rst", {31'd0, cpu_rst}, 32'd1);
        checkOutput("idle err", {31'd0, err}, 32'd0);
        checkOutput("idle done count", done_total, 32'd0);

        // Good frame with leading noise byte
        expectWrite(8'h10, 8'h11);
        expectWrite(8'h11, 8'h22);
        expectWrite(8'h12, 8'h33);
        frm = '{8'h00, 8'hA5, 8'h03, 8'h10, 8'h11, 8'h22, 8'h33, 8'h87};
        sendFrame();
        checkOutput("f1 done count", done_total - done_snap, 32'd1);
        checkOutput("f1 cpu_rst", {31'd0, cpu_rst}, 32'd0);
        checkOutput("f1 err", {31'd0, err}, 32'd0);
        checkOutput("f1 writes drained", rd_ptr, wr_ptr);

        // Same frame, bad checksum
        expectWrite(8'h10, 8'h11);
        expectWrite(8'h11, 8'h22);
        expectWrite(8'h12, 8'h33);
        frm = '{8'hA5, 8'h03, 8'h10, 8'h11, 8'h22, 8'h33, 8'h88};
        sendFrame();
        checkOutput("f2 done count", done_total - done_snap, 32'd0);
        checkOutput("f2 cpu_rst", {31'd0, cpu_rst}, 32'd1);
        checkOutput("f2 err", {31'd0, err}, 32'd1);
        checkOutput("f2 writes drained", rd_ptr, wr_ptr);

        // Address wrap 0xFF -> 0x00
        expectWrite(8'hFF, 8'hAA);
        expectWrite(8'h00, 8'hBB);
        frm = '{8'hA5, 8'h02, 8'hFF, 8'hAA, 8'hBB, 8'h9A};
        sendFrame();
        checkOutput("f3 done count", done_total - done_snap, 32'd1);
        checkOutput("f3 cpu_rst", {31'd0, cpu_rst}, 32'd0);
        checkOutput("f3 err", {31'd0, err}, 32'd0);
        checkOutput("f3 writes drained", rd_ptr, wr_ptr);

        // Framing error on a data byte
        frm = '{8'hA5, 8'h01, 8'h20};
        sendFrame();
        checkOutput("f4 cpu_rst after hdr", {31'd0, cpu_rst}, 32'd1);
        applyStimulus(8'h5A, 1'b0);
        repeat (20) @(negedge sys_clk);
        checkOutput("f4 err", {31'd0, err}, 32'd1);
        checkOutput("f4 cpu_rst", {31'd0, cpu_rst}, 32'd1);
        checkOutput("f4 done count", done_total - done_snap, 32'd0);
        checkOutput("f4 no writes", rd_ptr, wr_ptr);

        // Recovery frame: 01+40+5A+65 = 0x100
        expectWrite(8'h40, 8'h5A);
        frm = '{8'hA5, 8'h01, 8'h40, 8'h5A, 8'h65};
        sendFrame();
        checkOutput("f5 done count", done_total - done_snap, 32'd1);
        checkOutput("f5 cpu_rst", {31'd0, cpu_rst}, 32'd0);
        checkOutput("f5 err", {31'd0, err}, 32'd0);
        checkOutput("f5 writes drained", rd_ptr, wr_ptr);

`ifdef LOADER_TIMEOUT_EN
        // Stalled frame times out
        frm = '{8'hA5, 8'h03};
        sendFrame();
        repeat (1200) @(negedge sys_clk);
        checkOutput("to err", {31'd0, err}, 32'd1);
        checkOutput("to cpu_rst", {31'd0, cpu_rst}, 32'd1);
        checkOutput("to done count", done_total - done_snap, 32'd0);
        expectWrite(8'h40, 8'h5A);
        frm = '{8'hA5, 8'h01, 8'h40, 8'h5A, 8'h65};
        sendFrame();
        checkOutput("to recovery done", done_total - done_snap, 32'd1);
        checkOutput("to recovery err", {31'd0, err}, 32'd0);
        checkOutput("to writes drained", rd_ptr, wr_ptr);
`endif

        repeat (20) @(negedge sys_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
